// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - multi-program fetch sequencer with return stack
//
// Holds the instruction fetch address, launches one of NPROG programs on
// Start, and executes branch / call / return / halt / stall controls from
// the decoder.
//
// Ports:
//   Clk, Reset_n           clock, asynchronous active-low reset
//   Start, ProgSel         launch request and program index
//   ProgBase               flattened program entry addresses (entry k at [k*L +: L])
//   Stall                  freeze all state while running
//   BranchEn, IsEqual,
//   BranchRel, Target      conditional branch (absolute or signed PC-relative)
//   Call, Ret              subroutine call / return through the hardware stack
//   Halt                   end of program
//   ProgCtr                registered fetch address
//   Running, Done          status: launching/running, finished
//   StackErr               sticky stack overflow/underflow flag
module prog_sequencer #(
    parameter int L     = 10,
    parameter int NPROG = 4,
    parameter int DEPTH = 4
) (
    input  logic                                      Clk,
    input  logic                                      Reset_n,
    input  logic                                      Start,
    input  logic [((NPROG > 1) ? $clog2(NPROG) : 1)-1:0] ProgSel,
    input  logic [NPROG*L-1:0]                        ProgBase,
    input  logic                                      Stall,
    input  logic                                      BranchEn,
    input  logic                                      IsEqual,
    input  logic                                      BranchRel,
    input  logic                                      Call,
    input  logic                                      Ret,
    input  logic                                      Halt,
    input  logic [L-1:0]                              Target,
    output logic [L-1:0]                              ProgCtr,
    output logic                                      Running,
    output logic                                      Done,
    output logic                                      StackErr
);

    localparam int SW  = (NPROG > 1) ? $clog2(NPROG) : 1;
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [L-1:0]    pc, pc_n;
    logic [SPW-1:0]  sp, sp_n;
    logic [SPW-1:0]  sp_m1;
    logic            err, err_n;
    logic [SW-1:0]   sel, sel_n;
    logic            push;
    logic            launch;
    logic [IW-1:0]   wr_idx, rd_idx;
    logic [L-1:0]    stack_mem [DEPTH];

    // Out-of-range selections fall back to entry 0.
    function automatic logic [L-1:0] base_of(input logic [SW-1:0] s);
        logic [L-1:0] b;
        b = ProgBase[L-1:0];
        for (int k = 1; k < NPROG; k++) begin
            if (s == SW'(k)) b = ProgBase[k*L +: L];
        end
        return b;
    endfunction

    assign sp_m1  = sp - SPW'(1);
    assign wr_idx = sp[IW-1:0];
    assign rd_idx = sp_m1[IW-1:0];

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
            pc    <= '0;
            sp    <= '0;
            err   <= 1'b0;
            sel   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            sp    <= sp_n;
            err   <= err_n;
            sel   <= sel_n;
        end
    end

    // Stack storage needs no reset: entries above the pointer are never read.
    always_ff @(posedge Clk) begin
        if (push) stack_mem[wr_idx] <= pc + L'(1);
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        pc_n    = pc;
        sp_n    = sp;
        err_n   = err;
        sel_n   = sel;
        push    = 1'b0;
        launch  = 1'b0;

        case (state)
            S_IDLE: begin
                if (Start) launch = 1'b1;
            end
            S_LAUNCH: begin
                if (Start) begin
                    launch = 1'b1;
                end else begin
                    pc_n    = base_of(sel) + L'(1);
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (Start) begin
                    launch = 1'b1;
                end else if (Stall) begin
                    pc_n = pc;
                end else if (Halt) begin
                    state_n = S_DONE;
                end else if (Ret) begin
                    if (sp != '0) begin
                        pc_n = stack_mem[rd_idx];
                        sp_n = sp_m1;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_DONE;
                    end
                end else if (Call) begin
                    if (sp != SP_FULL) begin
                        push = 1'b1;
                        sp_n = sp + SPW'(1);
                        pc_n = Target;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_DONE;
                    end
                end else if (BranchEn && IsEqual) begin
                    // Two's-complement add gives the signed offset mod 2^L.
                    pc_n = BranchRel ? (pc + Target) : Target;
                end else begin
                    pc_n = pc + L'(1);
                end
            end
            S_DONE: begin
                if (Start) launch = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase

        // Any launch (fresh, re-sampled, abort or restart) starts clean.
        if (launch) begin
            state_n = S_LAUNCH;
            sel_n   = ProgSel;
            pc_n    = base_of(ProgSel);
            sp_n    = '0;
            err_n   = 1'b0;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        ProgCtr  = pc;
        Running  = (state == S_LAUNCH) || (state == S_RUN);
        Done     = (state == S_DONE);
        StackErr = err;
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - self-checking bench for prog_sequencer
module tb_prog_sequencer;

    localparam int L     = 10;
    localparam int NPROG = 3;
    localparam int DEPTH = 2;
    localparam int MASK  = (1 << L) - 1;

    logic              Clk;
    logic              Reset_n;
    logic              Start;
    logic [1:0]        ProgSel;
    logic [NPROG*L-1:0] ProgBase;
    logic              Stall, BranchEn, IsEqual, BranchRel, Call, Ret, Halt;
    logic [L-1:0]      Target;
    logic [L-1:0]      ProgCtr;
    logic              Running, Done, StackErr;

    int checks;
    int failures;

    // Reference model: mode 0 idle, 1 launch, 2 run, 3 done
    int m_mode;
    int m_pc;
    int m_sel;
    int m_err;
    int m_stack[$];

    prog_sequencer #(.L(L), .NPROG(NPROG), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ProgSel(ProgSel),
        .ProgBase(ProgBase), .Stall(Stall), .BranchEn(BranchEn),
        .IsEqual(IsEqual), .BranchRel(BranchRel), .Call(Call), .Ret(Ret),
        .Halt(Halt), .Target(Target), .ProgCtr(ProgCtr), .Running(Running),
        .Done(Done), .StackErr(StackErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int tb_base(input int s);
        int idx;
        idx = (s >= NPROG) ? 0 : s;
        return int'(ProgBase[idx*L +: L]);
    endfunction

    task automatic set_base(input int k, input int v);
        ProgBase[k*L +: L] = L'(v);
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 0;
        m_sel  = 0;
        m_err  = 0;
        m_stack.delete();
    endtask

    task automatic model_launch();
        m_sel  = int'(ProgSel);
        m_pc   = tb_base(m_sel);
        m_err  = 0;
        m_stack.delete();
        m_mode = 1;
    endtask

    task automatic model_clk();
        case (m_mode)
            0, 3: if (Start) model_launch();
            1: begin
                if (Start) model_launch();
                else begin
                    m_pc   = (tb_base(m_sel) + 1) & MASK;
                    m_mode = 2;
                end
            end
            default: begin
                if (Start) model_launch();
                else if (Stall) begin
                end else if (Halt) m_mode = 3;
                else if (Ret) begin
                    if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                    else begin m_err = 1; m_mode = 3; end
                end else if (Call) begin
                    if (m_stack.size() < DEPTH) begin
                        m_stack.push_back((m_pc + 1) & MASK);
                        m_pc = int'(Target);
                    end else begin m_err = 1; m_mode = 3; end
                end else if (BranchEn && IsEqual) begin
                    m_pc = BranchRel ? ((m_pc + int'(Target)) & MASK) : int'(Target);
                end else m_pc = (m_pc + 1) & MASK;
            end
        endcase
    endtask

    task automatic compare_model();
        check("pc", 32'(ProgCtr), 32'(m_pc));
        check("running", 32'(Running), 32'((m_mode == 1) || (m_mode == 2)));
        check("done", 32'(Done), 32'(m_mode == 3));
        check("stackerr", 32'(StackErr), 32'(m_err));
    endtask

    task automatic idle_inputs();
        Start = 0; Stall = 0; BranchEn = 0; IsEqual = 0; BranchRel = 0;
        Call = 0; Ret = 0; Halt = 0; Target = '0;
    endtask

    // One clock: model follows the sampled inputs, DUT checked 1 ns later.
    task automatic step();
        @(posedge Clk);
        model_clk();
        #1;
        compare_model();
    endtask

    task automatic step_pc(input string tag, input int exp);
        step();
        check(tag, 32'(ProgCtr), 32'(exp));
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        idle_inputs();
        ProgSel = '0;
        ProgBase = '0;
        set_base(0, 'h040);
        set_base(1, 'h150);
        set_base(2, 'h090);
        model_reset();
        Reset_n = 0;
        #12;
        check("reset_pc", 32'(ProgCtr), 0);
        check("reset_running", 32'(Running), 0);
        check("reset_done", 32'(Done), 0);
        check("reset_err", 32'(StackErr), 0);
        Reset_n = 1;
        @(negedge Clk);

        // Launch program 2
        Start = 1; ProgSel = 2;
        step(); check("launch_hold0", 32'(ProgCtr), 'h090);
        check("launch_running", 32'(Running), 1);
        step(); check("launch_hold1", 32'(ProgCtr), 'h090);
        Start = 0;
        step_pc("launch_plus1", 'h091);
        step_pc("run_092", 'h092);
        step_pc("run_093", 'h093);

        // Abort with out-of-range select (falls back to entry 0)
        set_base(0, 'h0FF);
        Start = 1; ProgSel = 3;
        step_pc("sel_oob", 'h0FF);
        step_pc("run_100", 'h100);
        BranchEn = 1; IsEqual = 1; BranchRel = 1; Target = 'h3FE;
        step_pc("br_rel_neg", 'h0FE);
        BranchEn = 1; IsEqual = 0; BranchRel = 1; Target = 'h3FE;
        step_pc("br_not_taken", 'h0FF);
        BranchEn = 1; IsEqual = 1; BranchRel = 0; Target = 'h020;
        step_pc("br_abs", 'h020);
        BranchEn = 1; IsEqual = 1; Target = 'h010;
        step_pc("br_abs2", 'h010);

        // Nested calls and returns
        Call = 1; Target = 'h200; step_pc("call1", 'h200);
        Call = 1; Target = 'h300; step_pc("call2", 'h300);
        Ret = 1; Call = 1; Target = 'h055; step_pc("ret1_over_call", 'h201);
        Ret = 1; step_pc("ret2", 'h011);
        Call = 1; Target = 'h200; step_pc("call3", 'h200);
        Call = 1; Target = 'h300; step_pc("call4", 'h300);
        Call = 1; Target = 'h050; step_pc("overflow_pc", 'h300);
        check("overflow_err", 32'(StackErr), 1);
        check("overflow_done", 32'(Done), 1);

        // Restart clears the error; then underflow
        Start = 1; ProgSel = 1;
        step_pc("restart", 'h150);
        check("restart_err", 32'(StackErr), 0);
        step_pc("restart_plus1", 'h151);
        Ret = 1; step_pc("underflow_pc", 'h151);
        check("underflow_err", 32'(StackErr), 1);
        check("underflow_done", 32'(Done), 1);

        // Wrap, stall, halt
        set_base(0, 'h3FE);
        Start = 1; ProgSel = 0;
        step_pc("wrap_base", 'h3FE);
        step_pc("wrap_3ff", 'h3FF);
        step_pc("wrap_000", 'h000);
        for (int i = 0; i < 3; i++) begin
            Stall = 1; Halt = 1; Call = 1;
            step_pc("stall_hold", 'h000);
        end
        Halt = 1; step_pc("halt_pc", 'h000);
        check("halt_done", 32'(Done), 1);
        check("halt_running", 32'(Running), 0);
        step_pc("halt_frozen", 'h000);

        // Abort from RUN clears the stack
        Start = 1; ProgSel = 2; step();
        idle_inputs(); step_pc("abort_run", 'h091);
        Call = 1; Target = 'h200; step_pc("abort_call", 'h200);
        Start = 1; ProgSel = 1; step_pc("abort_launch", 'h150);
        step_pc("abort_plus1", 'h151);
        Ret = 1; step_pc("abort_stack_empty", 'h151);
        check("abort_underflow", 32'(StackErr), 1);

        // Asynchronous reset between edges
        Start = 1; ProgSel = 2; step();
        idle_inputs(); step(); step();
        #2 Reset_n = 0;
        #1;
        model_reset();
        check("async_rst_pc", 32'(ProgCtr), 0);
        check("async_rst_running", 32'(Running), 0);
        #1 Reset_n = 1;
        step_pc("idle_after_rst", 0);

        // Randomized run against the model
        for (int k = 0; k < NPROG; k++) set_base(k, int'($urandom_range(0, MASK)));
        for (int i = 0; i < 3000; i++) begin
            int sp;
            sp      = (m_mode == 0 || m_mode == 3) ? 30 : 3;
            Start   = ($urandom_range(0, 99) < sp);
            ProgSel = 2'($urandom_range(0, 3));
            Stall   = ($urandom_range(0, 9) == 0);
            Halt    = ($urandom_range(0, 49) == 0);
            Ret     = ($urandom_range(0, 9) == 0);
            Call    = ($urandom_range(0, 9) == 0);
            BranchEn  = ($urandom_range(0, 4) == 0);
            IsEqual   = $urandom_range(0, 1) == 1;
            BranchRel = $urandom_range(0, 1) == 1;
            Target    = L'($urandom_range(0, MASK));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
